// File: rtl/cpu_bus_bridge.sv
// Memory-side bridge behind the 65CE02 core: zero-wait on-chip RAM, plus an
// I/O window reached over a slow req/ack handshake that stalls the core.
module cpu_bus_bridge #(
  parameter logic [3:0] IO_PAGE  = 4'hD,
  parameter int         TIMEOUT  = 16,
  parameter logic [7:0] TMO_DATA = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address_next,
  input  logic        write_next,
  input  logic [7:0]  data_o_next,
  input  logic        io_en,
  output logic        ready,
  output logic [7:0]  data_i,
  output logic        ram_en,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        io_req,
  output logic        io_we,
  output logic [15:0] io_addr,
  output logic [7:0]  io_wdata,
  input  logic        io_ack,
  input  logic [7:0]  io_rdata,
  output logic        bus_err,
  output logic [1:0]  dbg_state_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IO_WAIT = 2'd1;
  localparam logic [1:0] IO_DONE = 2'd2;

  localparam int             CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          io_req_q, io_req_d;
  logic          io_we_q, io_we_d;
  logic [15:0]   io_addr_q, io_addr_d;
  logic [7:0]    io_wdata_q, io_wdata_d;
  logic          bus_err_q, bus_err_d;
  logic [7:0]    hold_q, hold_d;
  logic          src_q, src_d;
  logic [7:0]    last_q, last_d;

  logic io_hit;
  logic accept;

  // Core handshake: ready is the only flow control. An access on the *_next
  // inputs commits at every rising edge where ready=1; while ready=0 the core
  // must hold still and the inputs are ignored. io_req/io_ack: io_req stays
  // high with stable io_* until an edge sees io_ack=1 (or the wait times out).
  assign io_hit = io_en & (address_next[15:12] == IO_PAGE);
  assign ready  = (state_q != IO_WAIT);
  assign accept = ready;

  assign ram_en    = accept & ~io_hit;
  assign ram_we    = ram_en & write_next;
  assign ram_addr  = address_next;
  assign ram_wdata = data_o_next;

  assign io_req      = io_req_q;
  assign io_we       = io_we_q;
  assign io_addr     = io_addr_q;
  assign io_wdata    = io_wdata_q;
  assign bus_err     = bus_err_q;
  assign dbg_state_o = state_q;

  // While stalled, keep presenting whatever the core saw before the stall.
  always_comb begin
    if (state_q == IO_WAIT) begin
      data_i = last_q;
    end else if (src_q) begin
      data_i = hold_q;
    end else begin
      data_i = ram_rdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    io_req_d   = io_req_q;
    io_we_d    = io_we_q;
    io_addr_d  = io_addr_q;
    io_wdata_d = io_wdata_q;
    bus_err_d  = 1'b0;
    hold_d     = hold_q;
    src_d      = src_q;
    last_d     = last_q;

    case (state_q)
      IDLE, IO_DONE: begin
        if (io_hit) begin
          state_d    = IO_WAIT;
          cnt_d      = '0;
          io_req_d   = 1'b1;
          io_we_d    = write_next;
          io_addr_d  = address_next;
          io_wdata_d = data_o_next;
        end else begin
          state_d = IDLE;
        end
      end
      IO_WAIT: begin
        // Ack takes priority over a timeout landing on the same edge.
        if (io_ack) begin
          state_d  = IO_DONE;
          io_req_d = 1'b0;
          if (!io_we_q) begin
            hold_d = io_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IO_DONE;
          io_req_d  = 1'b0;
          bus_err_d = 1'b1;
          if (!io_we_q) begin
            hold_d = TMO_DATA;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        io_req_d = 1'b0;
      end
    endcase

    if (accept) begin
      src_d  = io_hit;
      last_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      io_req_q   <= 1'b0;
      io_we_q    <= 1'b0;
      io_addr_q  <= '0;
      io_wdata_q <= '0;
      bus_err_q  <= 1'b0;
      hold_q     <= '0;
      src_q      <= 1'b0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      io_req_q   <= io_req_d;
      io_we_q    <= io_we_d;
      io_addr_q  <= io_addr_d;
      io_wdata_q <= io_wdata_d;
      bus_err_q  <= bus_err_d;
      hold_q     <= hold_d;
      src_q      <= src_d;
      last_q     <= last_d;
    end
  end

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Bench for cpu_bus_bridge: directed accesses from the test plan followed by
// random traffic, checked against a transaction-level model of the bridge.
module tb_cpu_bus_bridge;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address_next;
  logic        write_next;
  logic [7:0]  data_o_next;
  logic        io_en;
  logic        ready;
  logic [7:0]  data_i;
  logic        ram_en;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        io_req;
  logic        io_we;
  logic [15:0] io_addr;
  logic [7:0]  io_wdata;
  logic        io_ack;
  logic [7:0]  io_rdata;
  logic        bus_err;
  logic [1:0]  dbg_state;

  cpu_bus_bridge #(.IO_PAGE(4'hD), .TIMEOUT(TIMEOUT), .TMO_DATA(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .address_next(address_next), .write_next(write_next), .data_o_next(data_o_next),
    .io_en(io_en), .ready(ready), .data_i(data_i),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_rdata(io_rdata), .bus_err(bus_err),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- synchronous RAM attached to the bridge ----------------
  logic [7:0] ram_mem [0:65535];
  bit         ram_wr  [0:65535];
  logic [7:0] ram_rd_q;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'hA5;
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        ram_mem[ram_addr] <= ram_wdata;
        ram_wr[ram_addr]  <= 1'b1;
      end else begin
        ram_rd_q <= ram_wr[ram_addr] ? ram_mem[ram_addr] : pat(ram_addr);
      end
    end
  end
  assign ram_rdata = ram_rd_q;

  // ---------------- reference model state ----------------
  logic [7:0] ref_mem [int];
  logic [7:0] exp_hold;
  logic [7:0] exp_di;
  bit         exp_known;
  bit         exp_bus_err;

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(a);
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checks made at the start of every access: bridge idle or just done.
  task automatic check_open();
    check_eq("ready_open", ready, 1'b1);
    check_eq("io_req_open", io_req, 1'b0);
    check_eq("bus_err", bus_err, exp_bus_err);
    if (exp_known) check_eq("data_i", data_i, exp_di);
  endtask

  // One core access; ack_lat = wait cycle on which the device acks.
  task automatic do_access(input logic [15:0] addr, input logic we, input logic [7:0] wd,
                           input logic ioen, input int ack_lat, input logic [7:0] rd);
    bit         is_io;
    bit         timed;
    bit         stall_known;
    logic [7:0] stall_di;
    int         n;
    is_io = ioen && (addr[15:12] == 4'hD);
    @(negedge clk);
    check_open();
    stall_known  = exp_known;
    stall_di     = exp_di;
    address_next = addr;
    write_next   = we;
    data_o_next  = wd;
    io_en        = ioen;
    io_ack       = 1'($urandom_range(0, 1));
    io_rdata     = 8'($urandom);
    #1;
    check_eq("ram_en", ram_en, !is_io);
    check_eq("ram_we", ram_we, !is_io && we);
    check_eq("ram_addr", ram_addr, addr);
    check_eq("ram_wdata", ram_wdata, wd);
    exp_bus_err = 1'b0;
    if (!is_io) begin
      if (we) begin
        ref_mem[int'(addr)] = wd;
        exp_known = 1'b0;
      end else begin
        exp_known = 1'b1;
        exp_di    = ref_rd(addr);
      end
    end else begin
      n     = (ack_lat <= TIMEOUT) ? ack_lat : TIMEOUT;
      timed = (ack_lat > TIMEOUT);
      for (int k = 1; k <= n; k++) begin
        @(negedge clk);
        io_ack       = (k == ack_lat);
        io_rdata     = (k == ack_lat) ? rd : 8'($urandom);
        address_next = 16'($urandom);
        write_next   = 1'($urandom);
        data_o_next  = 8'($urandom);
        #1;
        check_eq("ready_stall", ready, 1'b0);
        check_eq("io_req_stall", io_req, 1'b1);
        check_eq("io_addr", io_addr, addr);
        check_eq("io_we", io_we, we);
        check_eq("io_wdata", io_wdata, wd);
        check_eq("bus_err_stall", bus_err, 1'b0);
        check_eq("ram_en_stall", ram_en, 1'b0);
        if (stall_known) check_eq("data_i_stall", data_i, stall_di);
      end
      if (!we) exp_hold = timed ? 8'hFF : rd;
      exp_known   = 1'b1;
      exp_di      = exp_hold;
      exp_bus_err = timed;
    end
  endtask

  // Reset asserted on the second wait cycle of an I/O read, then a stray ack.
  task automatic reset_mid_wait();
    @(negedge clk);
    check_open();
    address_next = 16'hD400;
    write_next   = 1'b0;
    data_o_next  = 8'h00;
    io_en        = 1'b1;
    io_ack       = 1'b0;
    @(negedge clk);
    check_eq("rst_ready_wait1", ready, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("rst_ready_async", ready, 1'b1);
    check_eq("rst_io_req_async", io_req, 1'b0);
    check_eq("rst_io_addr_async", io_addr, 16'h0000);
    @(negedge clk);
    reset        = 1'b1;
    address_next = 16'h0040;
    @(negedge clk);
    io_ack   = 1'b1;
    io_rdata = 8'h77;
    @(negedge clk);
    io_ack = 1'b0;
    #1;
    check_eq("late_ack_ready", ready, 1'b1);
    check_eq("late_ack_io_req", io_req, 1'b0);
    check_eq("late_ack_bus_err", bus_err, 1'b0);
    check_eq("late_ack_data_i", data_i, ref_rd(16'h0040));
    exp_hold    = 8'h00;
    exp_known   = 1'b1;
    exp_di      = ref_rd(16'h0040);
    exp_bus_err = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] a;
    logic [3:0]  page;
    int          r;
    int          lat;
    reset        = 1'b0;
    address_next = 16'h0000;
    write_next   = 1'b0;
    data_o_next  = 8'h00;
    io_en        = 1'b1;
    io_ack       = 1'b0;
    io_rdata     = 8'h00;
    exp_hold     = 8'h00;
    exp_di       = 8'h00;
    exp_known    = 1'b0;
    exp_bus_err  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_ready", ready, 1'b1);
    check_eq("rst_io_req", io_req, 1'b0);
    check_eq("rst_io_we", io_we, 1'b0);
    check_eq("rst_io_addr", io_addr, 16'h0000);
    check_eq("rst_io_wdata", io_wdata, 8'h00);
    check_eq("rst_bus_err", bus_err, 1'b0);
    check_eq("rst_dbg_idle", dbg_state, 2'd0);
    reset = 1'b1;

    do_access(16'h1234, 1'b1, 8'h5A, 1'b1, 0, 8'h00);
    do_access(16'h1234, 1'b0, 8'h00, 1'b1, 0, 8'h00);
    do_access(16'hD020, 1'b1, 8'h0E, 1'b1, 3, 8'h00);
    do_access(16'hD012, 1'b0, 8'h00, 1'b1, 2, 8'h80);
    do_access(16'hD013, 1'b0, 8'h00, 1'b1, 1, 8'h11);
    do_access(16'hD600, 1'b0, 8'h00, 1'b1, TIMEOUT + 4, 8'h00);
    do_access(16'hD601, 1'b0, 8'h00, 1'b1, TIMEOUT, 8'h3C);
    do_access(16'hD020, 1'b0, 8'h00, 1'b0, 0, 8'h00);
    do_access(16'hD020, 1'b1, 8'h42, 1'b0, 0, 8'h00);
    do_access(16'hD020, 1'b0, 8'h00, 1'b0, 0, 8'h00);
    reset_mid_wait();
    do_access(16'hD030, 1'b1, 8'h99, 1'b1, 2, 8'h00);

    for (int i = 0; i < 300; i++) begin
      page = ($urandom_range(0, 1) == 1) ? 4'hD : 4'($urandom_range(0, 15));
      a    = {page, 7'd0, 5'($urandom_range(0, 31))};
      r    = $urandom_range(0, 9);
      lat  = (r < 6) ? r + 1 : (r == 6) ? TIMEOUT - 1 : (r == 7) ? TIMEOUT :
             (r == 8) ? TIMEOUT + 1 : TIMEOUT + 5;
      do_access(a, 1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0), lat, 8'($urandom));
    end

    @(negedge clk);
    check_open();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
